// File: rtl/uart_pkg.sv
// Shared UART constants: system clock, standard-rate divisors and the divisor type.
// The optional baud_clk output of uart_baud_gen is enabled by defining BAUD_CLK_OUT_EN.
package uart_pkg;

  localparam int UART_CLK_FREQ_HZ = 50_000_000;
  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_DIV_WIDTH   = 16;

  // Divisors for 16x oversampling, rounded to nearest.
  localparam int UART_DIV_9600    = 326;
  localparam int UART_DIV_19200   = 163;
  localparam int UART_DIV_115200  = 27;
  localparam int UART_DEFAULT_DIV = UART_DIV_9600;

  typedef logic [UART_DIV_WIDTH-1:0] uart_div_t;

  function automatic uart_div_t uart_calc_div(input int baud, input int oversample);
    int denom;
    denom = baud * oversample;
    return uart_div_t'((UART_CLK_FREQ_HZ + denom / 2) / denom);
  endfunction

endpackage

// File: rtl/uart_mod_counter.sv
// Modulo-M counter with enable, synchronous clear and a terminal-count pulse.
// A modulus of 0 behaves as 1, so tc fires on every enabled cycle.
module uart_mod_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] mod,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] last;

  always_comb begin
    last = (mod == '0) ? '0 : mod - W'(1);
  end

  assign tc = en && (count == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: prescaler -> oversample counter -> os/mid/bit ticks.
// Define BAUD_CLK_OUT_EN to add the legacy square-wave output baud_clk.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = UART_DIV_WIDTH,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load,
  input  logic                 restart,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick
`ifdef BAUD_CLK_OUT_EN
  ,
  output logic                 baud_clk
`endif
);

  localparam int                OS_W   = $clog2(OVERSAMPLE) + 1;
  localparam logic [OS_W-1:0]   OS_MOD = OS_W'(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_MID = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] unused_pre_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 phase_clr;
  logic                 pre_tc;
  logic                 os_evt;
  logic                 mid_evt;
  logic                 bit_evt;

  // div_load and restart both restart the phase; div_load additionally latches div_in.
  assign phase_clr = div_load || restart;

  uart_mod_counter #(.W(DIV_WIDTH)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (phase_clr),
    .en    (en),
    .mod   (div_q),
    .count (unused_pre_cnt),
    .tc    (pre_tc)
  );

  assign os_evt = pre_tc && !phase_clr;

  uart_mod_counter #(.W(OS_W)) u_os_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (phase_clr),
    .en    (os_evt),
    .mod   (OS_MOD),
    .count (os_cnt),
    .tc    (bit_evt)
  );

  assign mid_evt = os_evt && (os_cnt == OS_MID);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      if (div_load) begin
        div_q <= div_in;
      end
      os_tick  <= os_evt;
      mid_tick <= mid_evt;
      bit_tick <= bit_evt;
    end
  end

`ifdef BAUD_CLK_OUT_EN
  // Rises at mid-bit, falls at the bit boundary: one full period per bit.
  always_ff @(posedge clk) begin
    if (rst || phase_clr) begin
      baud_clk <= 1'b0;
    end else if (mid_evt || bit_evt) begin
      baud_clk <= ~baud_clk;
    end
  end
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen (OVERSAMPLE = 4): per-cycle scoreboard
// plus a table of divisor/run-length vectors and hand-written corner sequences.
module tb_uart_baud_gen;

  localparam int DW  = 16;
  localparam int OS  = 4;
  localparam int DEF = 326;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] div_in;
  logic          div_load;
  logic          restart;
  logic          os_tick;
  logic          mid_tick;
  logic          bit_tick;
`ifdef BAUD_CLK_OUT_EN
  logic          baud_clk;
`endif

  uart_baud_gen #(
    .DIV_WIDTH   (DW),
    .OVERSAMPLE  (OS),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .restart  (restart),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
`ifdef BAUD_CLK_OUT_EN
    .bit_tick (bit_tick),
    .baud_clk (baud_clk)
`else
    .bit_tick (bit_tick)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // scoreboard: {baud_clk, bit_tick, mid_tick, os_tick} expected after each edge
  logic [3:0] exp_q[$];

  // reference model: enabled edges since phase origin
  int   m_div  = DEF;
  int   m_k    = 0;
  logic m_baud = 1'b0;

  int cnt_os, cnt_mid, cnt_bit;

  typedef struct {
    int div;
    int run_edges;
    int exp_os;
    int exp_mid;
    int exp_bit;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    logic [3:0] e;
    logic [3:0] a;
    int n;
    int j;
    @(posedge clk);
    e = 4'b0;
    if (rst) begin
      m_div = DEF; m_k = 0; m_baud = 1'b0;
    end else if (div_load) begin
      m_div = int'(div_in); m_k = 0; m_baud = 1'b0;
    end else if (restart) begin
      m_k = 0; m_baud = 1'b0;
    end else if (en) begin
      m_k++;
      n = (m_div == 0) ? 1 : m_div;
      if (m_k % n == 0) begin
        j = m_k / n;
        e[0] = 1'b1;
        e[1] = ((j % OS) == OS / 2);
        e[2] = ((j % OS) == 0);
        if (e[1] || e[2]) m_baud = ~m_baud;
      end
    end
`ifdef BAUD_CLK_OUT_EN
    e[3] = m_baud;
`endif
    exp_q.push_back(e);
    #1;
    a = {1'b0, bit_tick, mid_tick, os_tick};
`ifdef BAUD_CLK_OUT_EN
    a[3] = baud_clk;
`endif
    e = exp_q.pop_front();
    check("ticks_cycle", 32'(a), 32'(e));
    if (os_tick === 1'b1)  cnt_os++;
    if (mid_tick === 1'b1) cnt_mid++;
    if (bit_tick === 1'b1) cnt_bit++;
  endtask

  // driver tasks
  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load(input int d);
    div_in   = DW'(d);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
  endtask

  task automatic clr_counts();
    cnt_os = 0; cnt_mid = 0; cnt_bit = 0;
  endtask

  // sel: 0 = os_tick, 1 = mid_tick, 2 = bit_tick; edges = -1 on timeout
  task automatic wait_tick(input int sel, input int max, output int edges);
    logic hit;
    edges = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      hit = (sel == 0) ? os_tick : (sel == 1) ? mid_tick : bit_tick;
      if (hit === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int edges;

    vecs[0] = '{div: 4, run_edges: 32, exp_os: 8,  exp_mid: 2, exp_bit: 2};
    vecs[1] = '{div: 0, run_edges: 12, exp_os: 12, exp_mid: 3, exp_bit: 3};
    vecs[2] = '{div: 1, run_edges: 8,  exp_os: 8,  exp_mid: 2, exp_bit: 2};
    vecs[3] = '{div: 8, run_edges: 64, exp_os: 8,  exp_mid: 2, exp_bit: 2};
    vecs[4] = '{div: 3, run_edges: 25, exp_os: 8,  exp_mid: 2, exp_bit: 2};
    vecs[5] = '{div: 2, run_edges: 10, exp_os: 5,  exp_mid: 1, exp_bit: 1};

    rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0; restart = 1'b0;
    clr_counts();
    run(3);
    rst = 1'b0;
    check("reset_os", 32'(os_tick), 0);
    check("reset_bit", 32'(bit_tick), 0);
    en = 1'b1;

    // table-driven: period and tick counts per divisor
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].div);
      clr_counts();
      run(vecs[i].run_edges);
      check($sformatf("vec%0d_os", i), cnt_os, vecs[i].exp_os);
      check($sformatf("vec%0d_mid", i), cnt_mid, vecs[i].exp_mid);
      check($sformatf("vec%0d_bit", i), cnt_bit, vecs[i].exp_bit);
    end

    // first tick positions after load with N = 4
    load(4);
    wait_tick(0, 20, edges); check("first_os", edges, 4);
    load(4);
    wait_tick(1, 40, edges); check("first_mid", edges, 8);
    load(4);
    wait_tick(2, 40, edges); check("first_bit", edges, 16);
    wait_tick(2, 40, edges); check("bit_period", edges, 16);

    // en low for 7 cycles between ticks
    load(4);
    run(2);
    en = 1'b0;
    clr_counts();
    run(7);
    check("en_low_ticks", cnt_os + cnt_mid + cnt_bit, 0);
    en = 1'b1;
    wait_tick(0, 20, edges); check("en_resume_gap", edges, 2);
    wait_tick(0, 20, edges); check("en_next_gap", edges, 4);

    // restart one cycle before an expected bit_tick
    load(4);
    run(15);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_no_bit", 32'(bit_tick), 0);
    clr_counts();
    wait_tick(1, 40, edges); check("restart_mid_gap", edges, 8);
    check("restart_no_late_bit", cnt_bit, 0);

    // div_load and restart together mid-bit
    load(4);
    run(6);
    div_in = DW'(8); div_load = 1'b1; restart = 1'b1;
    step();
    div_load = 1'b0; restart = 1'b0;
    check("load_restart_os", 32'(os_tick), 0);
    wait_tick(0, 20, edges); check("load_restart_period", edges, 8);
    wait_tick(2, 60, edges); check("load_restart_bit", edges, 24);

    // reset mid-count returns to the default divisor
    load(8);
    run(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_os", 32'(os_tick), 0);
    check("rst_mid_mid", 32'(mid_tick), 0);
    wait_tick(0, 400, edges); check("rst_default_div", edges, DEF);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
